// File: rtl/ppu_pkg.sv
// PPU register-map constants shared by the OAM, the DMA engine and the other PPU register blocks.
package ppu_pkg;
  localparam logic [15:0] PPU_REG_BASE      = 16'h2000;
  localparam logic [2:0]  OAMADDR_IDX       = 3'd3;
  localparam logic [2:0]  OAMDATA_IDX       = 3'd4;
  localparam logic [15:0] OAMDMA            = 16'h4014;
  localparam logic [15:0] OAMDATA           = 16'h2004;
  localparam logic [7:0]  ATTR_MASK_DEFAULT = 8'hE3;
  localparam int          OAM_AW            = 8;

  // While rendering, $2004 writes only bump the sprite index (upper six bits).
  function automatic logic [OAM_AW-1:0] oam_addr_inc(input logic [OAM_AW-1:0] a,
                                                     input logic rendering);
    return rendering ? {a[7:2] + 6'd1, a[1:0]} : a + 8'd1;
  endfunction
endpackage

// File: rtl/ppu_oam_if.sv
// CPU/DMA register bus as seen by the PPU register blocks.
interface ppu_oam_if;
  logic        cpu_ce_i;
  logic [15:0] cpu_addr_i;
  logic [7:0]  cpu_data_i;
  logic        rw_i;
  logic [7:0]  cpu_data_o;
  logic        cpu_rd_en_o;

  modport master (output cpu_ce_i, cpu_addr_i, cpu_data_i, rw_i,
                  input  cpu_data_o, cpu_rd_en_o);
  modport slave  (input  cpu_ce_i, cpu_addr_i, cpu_data_i, rw_i,
                  output cpu_data_o, cpu_rd_en_o);
endinterface

// File: rtl/ppu_oam_ram.sv
// OAM storage: one write port, NUM_RD registered write-first read ports.
module ppu_oam_ram #(
  parameter int                  DEPTH  = 256,
  parameter int                  AW     = 8,
  parameter int                  DW     = 8,
  parameter int                  NUM_RD = 2,
  parameter logic [NUM_RD-1:0]   RD_RST = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [AW-1:0]                 waddr,
  input  logic [DW-1:0]                 wdata,
  input  logic [NUM_RD-1:0][AW-1:0]     raddr,
  output logic [NUM_RD-1:0][DW-1:0]     rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [DW-1:0] rd_nxt;
    assign rd_nxt = (we && waddr == raddr[i]) ? wdata : mem[raddr[i]];

    // Ports without reset keep tracking memory through rst, so they stay coherent afterwards.
    always_ff @(posedge clk)
      if (RD_RST[i] && rst) rdata[i] <= '0;
      else                  rdata[i] <= rd_nxt;
  end
endmodule

// File: rtl/ppu_oam.sv
// OAMADDR/OAMDATA register pair in front of the 256-byte OAM, plus the sprite read port.
module ppu_oam
  import ppu_pkg::*;
#(
  parameter logic [7:0] ATTR_MASK = ATTR_MASK_DEFAULT,
  parameter int         OAM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  ppu_oam_if.slave          bus,
  input  logic              rendering_i,
  input  logic              oamaddr_clr_i,
  input  logic [OAM_AW-1:0] spr_addr_i,
  output logic [7:0]        spr_data_o,
  output logic [OAM_AW-1:0] oam_addr_o
);
  localparam int RD_CPU = 0;
  localparam int RD_SPR = 1;

  logic              sel, wr2003, wr2004, rd2004, we;
  logic [OAM_AW-1:0] oam_addr, oam_addr_next;
  logic [7:0]        wdata;
  logic [1:0][OAM_AW-1:0] raddr;
  logic [1:0][7:0]        rdata;
  logic                   unused_addr;

  assign unused_addr = ^bus.cpu_addr_i[12:3];

  // Registers mirror every 8 bytes across $2000-$3FFF; rst forces the decode off.
  assign sel    = bus.cpu_ce_i & ~rst & (bus.cpu_addr_i[15:13] == PPU_REG_BASE[15:13]);
  assign wr2003 = sel & ~bus.rw_i & (bus.cpu_addr_i[2:0] == OAMADDR_IDX);
  assign wr2004 = sel & ~bus.rw_i & (bus.cpu_addr_i[2:0] == OAMDATA_IDX);
  assign rd2004 = sel &  bus.rw_i & (bus.cpu_addr_i[2:0] == OAMDATA_IDX);

  always_comb begin
    oam_addr_next = oam_addr;
    if (rst || oamaddr_clr_i) oam_addr_next = '0;
    else if (wr2003)          oam_addr_next = bus.cpu_data_i;
    else if (wr2004)          oam_addr_next = oam_addr_inc(oam_addr, rendering_i);
  end

  always_ff @(posedge clk)
    if (rst) oam_addr <= '0;
    else     oam_addr <= oam_addr_next;

  assign we    = wr2004 & ~rendering_i;
  assign wdata = (oam_addr[1:0] == 2'd2) ? (bus.cpu_data_i & ATTR_MASK) : bus.cpu_data_i;

  // The CPU port looks ahead at the next address so its registered data matches OAMADDR now.
  assign raddr[RD_CPU] = oam_addr_next;
  assign raddr[RD_SPR] = spr_addr_i;

  ppu_oam_ram #(
    .DEPTH (OAM_DEPTH),
    .AW    (OAM_AW),
    .DW    (8),
    .NUM_RD(2),
    .RD_RST(2'b10)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(oam_addr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign spr_data_o      = rdata[RD_SPR];
  assign oam_addr_o      = oam_addr;
  assign bus.cpu_rd_en_o = rd2004;
  assign bus.cpu_data_o  = !rd2004    ? 8'h00 :
                           rendering_i ? rdata[RD_SPR] : rdata[RD_CPU];
endmodule

// File: tb/tb_ppu_oam.sv
// Directed bench for ppu_oam: register decode, address stepping, attribute masking, ports.
module tb_ppu_oam;
  logic       clk = 1'b0;
  logic       rst;
  logic       rendering_i, oamaddr_clr_i;
  logic [7:0] spr_addr_i, spr_data_o, oam_addr_o;
  int         n_cmp = 0;
  int         n_err = 0;

  ppu_oam_if bus();

  ppu_oam dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rendering_i  (rendering_i),
    .oamaddr_clr_i(oamaddr_clr_i),
    .spr_addr_i   (spr_addr_i),
    .spr_data_o   (spr_data_o),
    .oam_addr_o   (oam_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_ce_i = 1'b1; bus.cpu_addr_i = a; bus.cpu_data_i = d; bus.rw_i = 1'b0;
    @(posedge clk); #1;
    bus.cpu_ce_i = 1'b0; bus.rw_i = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    bus.cpu_ce_i = 1'b1; bus.cpu_addr_i = 16'h2004; bus.rw_i = 1'b1;
    #1;
    chk({tag, "_rden"}, {7'd0, bus.cpu_rd_en_o}, 8'h01);
    chk(tag, bus.cpu_data_o, exp);
    @(posedge clk); #1;
    bus.cpu_ce_i = 1'b0;
  endtask

  task automatic spr_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk);
    spr_addr_i = a;
    @(posedge clk); #1;
    chk(tag, spr_data_o, exp);
  endtask

  initial begin
    rst = 1'b1; rendering_i = 1'b0; oamaddr_clr_i = 1'b0; spr_addr_i = 8'h00;
    bus.cpu_ce_i = 1'b0; bus.cpu_addr_i = 16'h0000; bus.cpu_data_i = 8'h00; bus.rw_i = 1'b1;
    repeat (2) @(posedge clk);

    // decode is forced off while rst is high, even with a $2004 read on the bus
    @(negedge clk);
    bus.cpu_ce_i = 1'b1; bus.cpu_addr_i = 16'h2004; bus.rw_i = 1'b1;
    #1;
    chk("rst_rden", {7'd0, bus.cpu_rd_en_o}, 8'h00);
    chk("rst_cpu_data", bus.cpu_data_o, 8'h00);
    @(posedge clk); #1;
    chk("rst_oam_addr", oam_addr_o, 8'h00);
    chk("rst_spr_data", spr_data_o, 8'h00);
    @(negedge clk);
    rst = 1'b0; bus.cpu_ce_i = 1'b0;

    // basic write/read sequence
    wr(16'h2003, 8'h10);
    wr(16'h2004, 8'hAA);
    wr(16'h2004, 8'hBB);
    chk("addr_after_2wr", oam_addr_o, 8'h12);
    wr(16'h2003, 8'h10);
    rd_chk("rd_10", 8'hAA);
    chk("addr_after_rd", oam_addr_o, 8'h10);
    spr_chk("spr_11", 8'h11, 8'hBB);

    // wrap at FF, mirrored $2003, non-PPU address ignored
    wr(16'h2003, 8'hFF);
    wr(16'h2004, 8'h55);
    chk("addr_wrap", oam_addr_o, 8'h00);
    spr_chk("spr_ff", 8'hFF, 8'h55);
    wr(16'h3FFB, 8'h44);
    chk("mirror_3ffb", oam_addr_o, 8'h44);
    wr(16'h4003, 8'h77);
    chk("non_ppu_addr", oam_addr_o, 8'h44);

    // attribute byte masking
    wr(16'h2003, 8'h02);
    wr(16'h2004, 8'hFF);
    wr(16'h2003, 8'h02);
    rd_chk("attr_mask", 8'hE3);
    wr(16'h2003, 8'h03);
    wr(16'h2004, 8'hFF);
    wr(16'h2003, 8'h03);
    rd_chk("no_mask_b3", 8'hFF);

    // writes while rendering: no RAM write, sprite-index increment
    wr(16'h2003, 8'h05);
    wr(16'h2004, 8'h11);
    rendering_i = 1'b1;
    wr(16'h2003, 8'h05);
    wr(16'h2004, 8'h77);
    chk("rend_inc", oam_addr_o, 8'h09);
    spr_chk("rend_spr05", 8'h05, 8'h11);
    rd_chk("rend_rd_mux", 8'h11);
    wr(16'h2003, 8'hFE);
    wr(16'h2004, 8'h00);
    chk("rend_wrap", oam_addr_o, 8'h02);
    rendering_i = 1'b0;
    wr(16'h2003, 8'h05);
    rd_chk("rend_no_write", 8'h11);

    // oamaddr_clr_i beats a simultaneous $2003 write
    @(negedge clk);
    oamaddr_clr_i = 1'b1;
    bus.cpu_ce_i = 1'b1; bus.cpu_addr_i = 16'h2003; bus.cpu_data_i = 8'h40; bus.rw_i = 1'b0;
    @(posedge clk); #1;
    oamaddr_clr_i = 1'b0; bus.cpu_ce_i = 1'b0; bus.rw_i = 1'b1;
    chk("clr_prio", oam_addr_o, 8'h00);

    // reset mid-stream drops the in-flight write
    wr(16'h2003, 8'h21);
    wr(16'h2004, 8'h5A);
    wr(16'h2003, 8'h20);
    wr(16'h2004, 8'h01);
    chk("pre_rst_addr", oam_addr_o, 8'h21);
    spr_chk("pre_rst_spr", 8'h21, 8'h5A);
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_ce_i = 1'b1; bus.cpu_addr_i = 16'h2004; bus.cpu_data_i = 8'h99; bus.rw_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; bus.cpu_ce_i = 1'b0; bus.rw_i = 1'b1;
    chk("mid_rst_addr", oam_addr_o, 8'h00);
    chk("mid_rst_spr", spr_data_o, 8'h00);
    wr(16'h2004, 8'h33);
    chk("post_rst_addr", oam_addr_o, 8'h01);
    spr_chk("post_rst_mem0", 8'h00, 8'h33);
    spr_chk("dropped_write", 8'h21, 8'h5A);

    // DMA-style fill: one $2004 write every 2 clks
    wr(16'h2003, 8'h00);
    for (int i = 0; i < 256; i++) begin
      wr(16'h2004, 8'(i));
      @(negedge clk);
    end
    chk("dma_addr_wrap", oam_addr_o, 8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] e;
      e = 8'(i);
      if ((i % 4) == 2) e = e & 8'hE3;
      spr_chk("dma_sweep", 8'(i), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
